// File: rtl/branch_predict_unit_pkg.sv
// Shared condition codes, 2-bit counter encodings and the counter update rule
// for the branch resolution / prediction block.
package branch_pkg;

    localparam logic [2:0] COND_BEQ  = 3'b000;
    localparam logic [2:0] COND_BNE  = 3'b001;
    localparam logic [2:0] COND_JMP  = 3'b010;
    localparam logic [2:0] COND_NOP  = 3'b011;
    localparam logic [2:0] COND_BLT  = 3'b100;
    localparam logic [2:0] COND_BGE  = 3'b101;
    localparam logic [2:0] COND_BLTU = 3'b110;
    localparam logic [2:0] COND_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RST = WNT;

    // Saturating up/down step of a 2-bit predictor counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == ST) ? ST : c + 2'd1;
        else       return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// Direct-mapped table of 2-bit saturating counters: combinational read,
// synchronous update, synchronous active-low reset of every entry to WNT.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_IDX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BHT_IDX-1:0] rd_idx,
    output logic [1:0]         rd_ctr,
    input  logic               wr_en,
    input  logic [BHT_IDX-1:0] wr_idx,
    input  logic               wr_taken
);

    localparam int DEPTH = 2 ** BHT_IDX;

    logic [1:0] tbl [DEPTH];

    // Read sees the stored value, so a same-cycle update is not forwarded.
    assign rd_ctr = tbl[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= BHT_RST;
        end else if (wr_en) begin
            tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a 2-bit BHT: registered outcome, mispredict,
// flush and redirect one cycle after accept, plus a saturating mispredict count.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PC_WIDTH  = 8,
    parameter int BHT_IDX   = 4,
    parameter int PC_INC    = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 if_pred_taken,
    input  logic                 ex_valid,
    input  logic                 ex_stall,
    input  logic [2:0]           ex_cond,
    input  logic [WIDTH-1:0]     ex_a,
    input  logic [WIDTH-1:0]     ex_b,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic [PC_WIDTH-1:0]  ex_target,
    input  logic                 ex_pred_taken,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 mispredict,
    output logic                 flush,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    logic       accept;
    logic       taken;
    logic       mis;
    logic [1:0] if_ctr;

    // Only the index bits of each PC address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:BHT_IDX], ex_pc[PC_WIDTH-1:BHT_IDX], if_ctr[0]};

    assign accept        = ex_valid && !ex_stall;
    assign mis           = taken != ex_pred_taken;
    assign if_pred_taken = if_ctr[1];

    always_comb begin
        taken = 1'b0;
        case (ex_cond)
            COND_BEQ:  taken = ex_a == ex_b;
            COND_BNE:  taken = ex_a != ex_b;
            COND_JMP:  taken = 1'b1;
            COND_NOP:  taken = 1'b0;
            COND_BLT:  taken = $signed(ex_a) <  $signed(ex_b);
            COND_BGE:  taken = $signed(ex_a) >= $signed(ex_b);
            COND_BLTU: taken = ex_a <  ex_b;
            COND_BGEU: taken = ex_a >= ex_b;
            default:   taken = 1'b0;
        endcase
    end

    bht_2bit #(.BHT_IDX(BHT_IDX)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[BHT_IDX-1:0]),
        .rd_ctr   (if_ctr),
        .wr_en    (accept),
        .wr_idx   (ex_pc[BHT_IDX-1:0]),
        .wr_taken (taken)
    );

    // Pulses drop every non-accept cycle; outcome and redirect hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            mispredict     <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            res_valid  <= accept;
            mispredict <= accept && mis;
            flush      <= accept && mis;
            if (accept) begin
                res_taken   <= taken;
                redirect_pc <= taken ? ex_target : ex_pc + PC_WIDTH'(PC_INC);
                if (mis && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit plus hand-written
// sequences for training, stall, same-index lookup and mid-stream reset.
module tb_branch_predict_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall;
    logic [2:0]  ex_cond;
    logic [7:0]  ex_a, ex_b, ex_pc, ex_target;
    logic        ex_pred_taken;
    logic        res_valid, res_taken, mispredict, flush;
    logic [7:0]  redirect_pc;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_cond        (ex_cond),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .mispredict     (mispredict),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic [2:0] cond;
        logic [7:0] a, b, pc, tgt;
        logic       pred;
        logic       taken, mis;
        logic [7:0] redir;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] pc, input logic [7:0] tgt, input logic pred);
        ex_valid = 1'b1; ex_stall = 1'b0; ex_cond = c;
        ex_a = a; ex_b = b; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".res_valid"},  res_valid,      0);
        chk({tag, ".res_taken"},  res_taken,      0);
        chk({tag, ".mispredict"}, mispredict,     0);
        chk({tag, ".flush"},      flush,          0);
        chk({tag, ".redirect"},   redirect_pc,    0);
        chk({tag, ".cnt"},        mispredict_cnt, 0);
    endtask

    initial begin
        int exp_cnt;
        logic exp_pred [5];

        vecs[0]  = '{COND_BLT,  8'h80, 8'h01, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8'h20};
        vecs[1]  = '{COND_BLTU, 8'h80, 8'h01, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[2]  = '{COND_BGE,  8'h80, 8'h01, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[3]  = '{COND_BGEU, 8'h80, 8'h01, 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 8'h20};
        vecs[4]  = '{COND_BEQ,  8'h5A, 8'h5A, 8'h21, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55};
        vecs[5]  = '{COND_BNE,  8'h5A, 8'h5A, 8'h21, 8'h55, 1'b0, 1'b0, 1'b0, 8'h22};
        vecs[6]  = '{COND_JMP,  8'h00, 8'h00, 8'h42, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77};
        vecs[7]  = '{COND_NOP,  8'h00, 8'h00, 8'h42, 8'h77, 1'b1, 1'b0, 1'b1, 8'h43};
        vecs[8]  = '{COND_BEQ,  8'h01, 8'h02, 8'hFF, 8'h12, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[9]  = '{COND_BNE,  8'h01, 8'h02, 8'h30, 8'h40, 1'b0, 1'b1, 1'b1, 8'h40};
        vecs[10] = '{COND_BLT,  8'h7F, 8'h80, 8'h50, 8'h60, 1'b0, 1'b0, 1'b0, 8'h51};
        vecs[11] = '{COND_BGEU, 8'h00, 8'hFF, 8'h50, 8'h60, 1'b1, 1'b0, 1'b1, 8'h51};

        if_pc = 8'h03; ex_cond = '0; ex_a = '0; ex_b = '0; ex_pc = '0;
        ex_target = '0; ex_pred_taken = 1'b0;

        // Reset state
        do_reset();
        chk_all_zero("reset");
        chk("reset.if_pred", if_pred_taken, 0);

        // Back-to-back condition / redirect vectors
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].tgt, vecs[i].pred);
            step();
            if (vecs[i].mis) exp_cnt++;
            chk($sformatf("vec%0d.valid", i),    res_valid,   1);
            chk($sformatf("vec%0d.taken", i),    res_taken,   vecs[i].taken);
            chk($sformatf("vec%0d.mis", i),      mispredict,  vecs[i].mis);
            chk($sformatf("vec%0d.flush", i),    flush,       vecs[i].mis);
            chk($sformatf("vec%0d.redirect", i), redirect_pc, vecs[i].redir);
            chk($sformatf("vec%0d.cnt", i),      mispredict_cnt, exp_cnt);
        end
        idle();
        step();
        chk("vec_end.valid", res_valid, 0);
        chk("vec_end.mis",   mispredict, 0);
        chk("vec_end.hold_taken",    res_taken,   vecs[11].taken);
        chk("vec_end.hold_redirect", redirect_pc, vecs[11].redir);

        // Training at pc 03: 01->10->11->11->11
        do_reset();
        exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        if_pc = 8'h03;
        for (int i = 0; i < 5; i++) begin
            drive(COND_BEQ, 8'h33, 8'h33, 8'h03, 8'h80, if_pred_taken);
            #1;
            chk($sformatf("train%0d.pred", i), if_pred_taken, exp_pred[i]);
            step();
            chk($sformatf("train%0d.mis", i), mispredict, (i == 0));
        end
        chk("train.cnt", mispredict_cnt, 1);
        // Saturated at 11: one not-taken leaves 10 (still taken), second gives 01
        drive(COND_BNE, 8'h33, 8'h33, 8'h03, 8'h80, if_pred_taken);
        step();
        chk("sat.nt1.pred", if_pred_taken, 1);
        chk("sat.nt1.redirect", redirect_pc, 8'h04);
        drive(COND_BNE, 8'h33, 8'h33, 8'h03, 8'h80, if_pred_taken);
        step();
        chk("sat.nt2.pred", if_pred_taken, 0);
        chk("sat.cnt", mispredict_cnt, 3);

        // Stall: held branch does nothing for 3 cycles, then resolves once
        drive(COND_JMP, 8'h00, 8'h00, 8'h03, 8'h40, 1'b0);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.valid", i), res_valid, 0);
            chk($sformatf("stall%0d.pred", i),  if_pred_taken, 0);
        end
        chk("stall.cnt", mispredict_cnt, 3);
        ex_stall = 1'b0;
        step();
        chk("release.valid",    res_valid, 1);
        chk("release.mis",      mispredict, 1);
        chk("release.redirect", redirect_pc, 8'h40);
        idle();
        step();
        chk("release.pulse_end", res_valid, 0);
        chk("release.flush_end", flush, 0);
        chk("release.cnt", mispredict_cnt, 4);

        // Same-index read-before-write
        do_reset();
        if_pc = 8'h13;
        drive(COND_JMP, 8'h00, 8'h00, 8'h03, 8'h40, 1'b0);
        #1;
        chk("rbw.before", if_pred_taken, 0);
        step();
        idle();
        #1;
        chk("rbw.after", if_pred_taken, 1);

        // Reset mid-stream: counter 11, mispredict at edge N, reset at N+1
        do_reset();
        if_pc = 8'h03;
        drive(COND_JMP, 8'h00, 8'h00, 8'h03, 8'h40, 1'b1);
        step();
        step();
        drive(COND_NOP, 8'h00, 8'h00, 8'h03, 8'h40, 1'b1);
        step();
        chk("midrst.N.mis", mispredict, 1);
        chk("midrst.N.pred", if_pred_taken, 1);
        rst_n = 1'b0;
        drive(COND_JMP, 8'h00, 8'h00, 8'h03, 8'h40, 1'b0);
        step();
        chk_all_zero("midrst");
        chk("midrst.pred", if_pred_taken, 0);
        rst_n = 1'b1;
        idle();
        step();
        chk_all_zero("postrst");
        chk("postrst.pred", if_pred_taken, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
